// File: rtl/spec_rat_pkg.sv
// Shared rename-stage types: RRAT copy packet, speculative RAT entry and lane packets.
// Holds widths used by both the speculative and retirement rename tables.
// Lane packets travel on flat port vectors; these types give them structure inside.
package spec_rat_pkg;

  localparam int SCALAR         = 2;
  localparam int NUM_ENTRIES    = 32;
  localparam int PREG_IDX_WIDTH = 6;
  localparam int AREG_IDX_WIDTH = $clog2(NUM_ENTRIES);

  localparam logic [AREG_IDX_WIDTH-1:0] ZERO_REG = '0;

  // One committed mapping as read out of the retirement RAT.
  typedef struct packed {
    logic [PREG_IDX_WIDTH-1:0] tag;
  } RRAT_READ_OUTPACKET;

  // Speculative map entry: current phys tag and whether its value exists yet.
  typedef struct packed {
    logic [PREG_IDX_WIDTH-1:0] tag;
    logic                      ready;
  } RAT_ENTRY;

  typedef RAT_ENTRY [NUM_ENTRIES-1:0] RAT_TABLE;

  typedef struct packed {
    logic                      valid;
    logic [AREG_IDX_WIDTH-1:0] src1;
    logic [AREG_IDX_WIDTH-1:0] src2;
    logic [AREG_IDX_WIDTH-1:0] dest;
    logic                      dest_valid;
    logic [PREG_IDX_WIDTH-1:0] new_tag;
  } RAT_RENAME_INPACKET;

  typedef struct packed {
    logic                      valid;
    logic [PREG_IDX_WIDTH-1:0] src1_tag;
    logic                      src1_ready;
    logic [PREG_IDX_WIDTH-1:0] src2_tag;
    logic                      src2_ready;
    logic [PREG_IDX_WIDTH-1:0] old_dest_tag;
  } RAT_RENAME_OUTPACKET;

  typedef struct packed {
    logic                      valid;
    logic [PREG_IDX_WIDTH-1:0] tag;
  } CDB_PACKET;

  localparam int RRAT_W = $bits(RRAT_READ_OUTPACKET);
  localparam int RIN_W  = $bits(RAT_RENAME_INPACKET);
  localparam int ROUT_W = $bits(RAT_RENAME_OUTPACKET);
  localparam int CDB_W  = $bits(CDB_PACKET);

  // A lane changes the map only when it carries a real destination (x0 is never renamed).
  function automatic logic lane_writes(input RAT_RENAME_INPACKET p);
    return p.valid & p.dest_valid & (p.dest != ZERO_REG);
  endfunction

  // Identity map with every value present; the retirement RAT resets to the same map.
  function automatic RAT_TABLE reset_table();
    RAT_TABLE t;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      t[i].tag   = PREG_IDX_WIDTH'(i);
      t[i].ready = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/rat_src_bypass.sv
// Resolves one source operand to {phys tag, ready} from table value plus same-cycle bypasses.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is valid whenever the inputs are.
module rat_src_bypass
  import spec_rat_pkg::*;
(
  input  logic [AREG_IDX_WIDTH-1:0]        src_i,
  input  logic [PREG_IDX_WIDTH-1:0]        ent_tag_i,
  input  logic                             ent_ready_i,
  input  logic [SCALAR-1:0]                cdb_vld_i,
  input  logic [SCALAR*PREG_IDX_WIDTH-1:0] cdb_tag_i,
  input  logic                             older_wr_i,
  input  logic [AREG_IDX_WIDTH-1:0]        older_dest_i,
  input  logic [PREG_IDX_WIDTH-1:0]        older_tag_i,
  output logic [PREG_IDX_WIDTH-1:0]        tag_o,
  output logic                             ready_o
);

  logic cdb_hit;

  // A completing phys reg this cycle makes the stored mapping ready right away.
  always_comb begin
    cdb_hit = 1'b0;
    for (int j = 0; j < SCALAR; j++) begin
      if (cdb_vld_i[j] && (cdb_tag_i[j*PREG_IDX_WIDTH +: PREG_IDX_WIDTH] == ent_tag_i)) begin
        cdb_hit = 1'b1;
      end
    end
  end

  // x0 is hardwired; an older lane's fresh mapping shadows the table and any CDB hit on the stale tag.
  always_comb begin
    if (src_i == ZERO_REG) begin
      tag_o   = '0;
      ready_o = 1'b1;
    end else if (older_wr_i && (older_dest_i == src_i)) begin
      tag_o   = older_tag_i;
      ready_o = 1'b0;
    end else begin
      tag_o   = ent_tag_i;
      ready_o = ent_ready_i | cdb_hit;
    end
  end

endmodule

// File: rtl/spec_rat.sv
// Speculative front-end rename table: maps arch regs to phys tags with per-entry ready bits.
// Latency: rename lookup is combinational (0 cycles); table updates land at the next clock edge.
// Backpressure: none; rollback suppresses all rename outputs and overwrites the map in one cycle.
module spec_rat
  import spec_rat_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            rollback,
  input  logic [NUM_ENTRIES*RRAT_W-1:0]   rrat_copy_packet,
  input  logic [SCALAR*RIN_W-1:0]         rename_in,
  input  logic [SCALAR*CDB_W-1:0]         cdb_in,
  output logic [SCALAR*ROUT_W-1:0]        rename_out
);

  RAT_TABLE table_q;
  RAT_TABLE table_d;

  RAT_RENAME_INPACKET              rin       [SCALAR];
  CDB_PACKET                       cdb       [SCALAR];
  logic [SCALAR-1:0]               lane_wr;
  logic [SCALAR-1:0]               cdb_vld;
  logic [SCALAR*PREG_IDX_WIDTH-1:0] cdb_tags;

  logic [SCALAR-1:0]               older_wr;
  logic [AREG_IDX_WIDTH-1:0]       older_dest [SCALAR];
  logic [PREG_IDX_WIDTH-1:0]       older_tag  [SCALAR];

  logic [PREG_IDX_WIDTH-1:0]       s1_tag [SCALAR];
  logic [PREG_IDX_WIDTH-1:0]       s2_tag [SCALAR];
  logic [SCALAR-1:0]               s1_rdy;
  logic [SCALAR-1:0]               s2_rdy;

  // Unpack lane and CDB vectors and flag which lanes actually write the map.
  always_comb begin
    for (int k = 0; k < SCALAR; k++) begin
      rin[k]     = rename_in[k*RIN_W +: RIN_W];
      cdb[k]     = cdb_in[k*CDB_W +: CDB_W];
      lane_wr[k] = lane_writes(rin[k]);
      cdb_vld[k] = cdb[k].valid;
      cdb_tags[k*PREG_IDX_WIDTH +: PREG_IDX_WIDTH] = cdb[k].tag;
    end
  end

  // Each lane sees the immediately older lane's destination; lane 0 has no older lane.
  always_comb begin
    older_wr[0]   = 1'b0;
    older_dest[0] = ZERO_REG;
    older_tag[0]  = '0;
    for (int k = 1; k < SCALAR; k++) begin
      older_wr[k]   = lane_wr[k-1];
      older_dest[k] = rin[k-1].dest;
      older_tag[k]  = rin[k-1].new_tag;
    end
  end

  for (genvar k = 0; k < SCALAR; k++) begin : g_lane
    rat_src_bypass u_src1 (
      .src_i       (rin[k].src1),
      .ent_tag_i   (table_q[rin[k].src1].tag),
      .ent_ready_i (table_q[rin[k].src1].ready),
      .cdb_vld_i   (cdb_vld),
      .cdb_tag_i   (cdb_tags),
      .older_wr_i  (older_wr[k]),
      .older_dest_i(older_dest[k]),
      .older_tag_i (older_tag[k]),
      .tag_o       (s1_tag[k]),
      .ready_o     (s1_rdy[k])
    );

    rat_src_bypass u_src2 (
      .src_i       (rin[k].src2),
      .ent_tag_i   (table_q[rin[k].src2].tag),
      .ent_ready_i (table_q[rin[k].src2].ready),
      .cdb_vld_i   (cdb_vld),
      .cdb_tag_i   (cdb_tags),
      .older_wr_i  (older_wr[k]),
      .older_dest_i(older_dest[k]),
      .older_tag_i (older_tag[k]),
      .tag_o       (s2_tag[k]),
      .ready_o     (s2_rdy[k])
    );
  end

  // Assemble rename results; old_dest_tag follows the youngest older lane writing the same reg.
  always_comb begin
    RAT_RENAME_OUTPACKET       rout;
    logic [PREG_IDX_WIDTH-1:0] old_tag;
    rename_out = '0;
    for (int k = 0; k < SCALAR; k++) begin
      rout    = '0;
      old_tag = '0;
      if (rin[k].valid && !rollback) begin
        rout.valid      = 1'b1;
        rout.src1_tag   = s1_tag[k];
        rout.src1_ready = s1_rdy[k];
        rout.src2_tag   = s2_tag[k];
        rout.src2_ready = s2_rdy[k];
        if (lane_wr[k]) begin
          old_tag = table_q[rin[k].dest].tag;
          for (int j = 0; j < k; j++) begin
            if (lane_wr[j] && (rin[j].dest == rin[k].dest)) begin
              old_tag = rin[j].new_tag;
            end
          end
        end
        rout.old_dest_tag = old_tag;
      end
      rename_out[k*ROUT_W +: ROUT_W] = rout;
    end
  end

  // Next map: rollback restores the committed map; otherwise CDB marks ready, renames override it.
  always_comb begin
    table_d = table_q;
    if (rollback) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        table_d[i].tag   = rrat_copy_packet[i*RRAT_W +: PREG_IDX_WIDTH];
        table_d[i].ready = 1'b1;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        for (int j = 0; j < SCALAR; j++) begin
          if (cdb[j].valid && (cdb[j].tag == table_q[i].tag)) begin
            table_d[i].ready = 1'b1;
          end
        end
      end
      // Later lanes are younger, so iterating in order lets the youngest writer win.
      for (int k = 0; k < SCALAR; k++) begin
        if (lane_wr[k]) begin
          table_d[rin[k].dest].tag   = rin[k].new_tag;
          table_d[rin[k].dest].ready = 1'b0;
        end
      end
    end
  end

  // Map storage; reset snaps straight back to the identity map.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      table_q <= reset_table();
    end else begin
      table_q <= table_d;
    end
  end

endmodule

// File: tb/tb_spec_rat.sv
module tb_spec_rat;
  import spec_rat_pkg::*;

  logic                          clock = 1'b0;
  logic                          reset;
  logic                          rollback;
  logic [NUM_ENTRIES*RRAT_W-1:0] rrat_copy_packet;
  logic [SCALAR*RIN_W-1:0]       rename_in;
  logic [SCALAR*CDB_W-1:0]       cdb_in;
  logic [SCALAR*ROUT_W-1:0]      rename_out;

  RAT_RENAME_INPACKET        rin_tb  [SCALAR];
  CDB_PACKET                 cdb_tb  [SCALAR];
  logic [PREG_IDX_WIDTH-1:0] copy_tb [NUM_ENTRIES];
  RAT_RENAME_OUTPACKET       dout    [SCALAR];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference map: arch reg -> (tag, ready), advanced once per clock.
  int                  m_tag [NUM_ENTRIES];
  bit                  m_rdy [NUM_ENTRIES];
  int                  n_tag [NUM_ENTRIES];
  bit                  n_rdy [NUM_ENTRIES];
  RAT_RENAME_OUTPACKET e_out [SCALAR];

  spec_rat dut (
    .clock           (clock),
    .reset           (reset),
    .rollback        (rollback),
    .rrat_copy_packet(rrat_copy_packet),
    .rename_in       (rename_in),
    .cdb_in          (cdb_in),
    .rename_out      (rename_out)
  );

  always #5 clock = ~clock;

  always_comb begin
    for (int k = 0; k < SCALAR; k++) begin
      rename_in[k*RIN_W +: RIN_W] = rin_tb[k];
      cdb_in[k*CDB_W +: CDB_W]    = cdb_tb[k];
      dout[k]                     = rename_out[k*ROUT_W +: ROUT_W];
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      rrat_copy_packet[i*RRAT_W +: RRAT_W] = copy_tb[i];
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      m_tag[i] = i;
      m_rdy[i] = 1'b1;
    end
  endfunction

  // Renaming a group is the same as renaming its lanes one after another against a working
  // copy of the map, where completions seen this cycle already count as ready.
  function automatic void model_eval();
    int                  t_tag [NUM_ENTRIES];
    bit                  t_rdy [NUM_ENTRIES];
    RAT_RENAME_INPACKET  p;
    RAT_RENAME_OUTPACKET o;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      t_tag[i] = m_tag[i];
      t_rdy[i] = m_rdy[i];
      for (int j = 0; j < SCALAR; j++)
        if (cdb_tb[j].valid && int'(cdb_tb[j].tag) == m_tag[i]) t_rdy[i] = 1'b1;
    end
    for (int k = 0; k < SCALAR; k++) begin
      p = rin_tb[k];
      o = '0;
      if (p.valid && !rollback) begin
        o.valid      = 1'b1;
        o.src1_tag   = (p.src1 == 0) ? 6'd0 : 6'(t_tag[p.src1]);
        o.src1_ready = (p.src1 == 0) ? 1'b1 : t_rdy[p.src1];
        o.src2_tag   = (p.src2 == 0) ? 6'd0 : 6'(t_tag[p.src2]);
        o.src2_ready = (p.src2 == 0) ? 1'b1 : t_rdy[p.src2];
        if (p.dest_valid && p.dest != 0) o.old_dest_tag = 6'(t_tag[p.dest]);
      end
      if (p.valid && p.dest_valid && p.dest != 0) begin
        t_tag[p.dest] = int'(p.new_tag);
        t_rdy[p.dest] = 1'b0;
      end
      e_out[k] = o;
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      n_tag[i] = rollback ? int'(copy_tb[i]) : t_tag[i];
      n_rdy[i] = rollback ? 1'b1 : t_rdy[i];
    end
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      model_reset();
    end else begin
      model_eval();
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        m_tag[i] = n_tag[i];
        m_rdy[i] = n_rdy[i];
      end
    end
  end

  // Compare every lane against the model once per cycle, mid-cycle.
  always @(negedge clock) begin
    if (chk_en) begin
      model_eval();
      for (int k = 0; k < SCALAR; k++) begin
        total++;
        if (dout[k] !== e_out[k]) begin
          bad++;
          $display("FAIL model_lane%0d @%0t: got %h exp %h", k, $time, dout[k], e_out[k]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d exp %0d", nm, got, exp);
    end
  endtask

  task automatic clr();
    for (int k = 0; k < SCALAR; k++) begin
      rin_tb[k] = '0;
      cdb_tb[k] = '0;
    end
  endtask

  task automatic set_lane(input int k, input bit v, input int s1, input int s2,
                          input int d, input bit dv, input int nt);
    rin_tb[k].valid      = v;
    rin_tb[k].src1       = 5'(s1);
    rin_tb[k].src2       = 5'(s2);
    rin_tb[k].dest       = 5'(d);
    rin_tb[k].dest_valid = dv;
    rin_tb[k].new_tag    = 6'(nt);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    clr();
  endtask

  function automatic int pick_reg();
    return ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
  endfunction

  initial begin
    model_reset();
    reset    = 1'b1;
    rollback = 1'b0;
    clr();
    for (int i = 0; i < NUM_ENTRIES; i++) copy_tb[i] = '0;

    // Reset map visible while reset is held.
    #2;
    set_lane(0, 1, 5, 0, 0, 0, 0);
    #1;
    chk("rst_valid",    dout[0].valid, 1);
    chk("rst_src1_tag", dout[0].src1_tag, 5);
    chk("rst_src1_rdy", dout[0].src1_ready, 1);
    chk("rst_src2_tag", dout[0].src2_tag, 0);
    chk("rst_src2_rdy", dout[0].src2_ready, 1);
    chk_en = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    #3 chk("t1_src1_tag", dout[0].src1_tag, 5);

    // Intra-group dependency on the same destination.
    next_cycle();
    set_lane(0, 1, 1, 2, 3, 1, 40);
    set_lane(1, 1, 3, 4, 3, 1, 41);
    #3;
    chk("t2_l1_src1_tag", dout[1].src1_tag, 40);
    chk("t2_l1_src1_rdy", dout[1].src1_ready, 0);
    chk("t2_l0_old",      dout[0].old_dest_tag, 3);
    chk("t2_l1_old",      dout[1].old_dest_tag, 40);
    chk("t2_l1_src2_tag", dout[1].src2_tag, 4);
    next_cycle();
    set_lane(0, 1, 3, 0, 0, 0, 0);
    #3;
    chk("t2_e3_tag", dout[0].src1_tag, 41);
    chk("t2_e3_rdy", dout[0].src1_ready, 0);

    // CDB bypass on a read, then the ready bit persists.
    next_cycle();
    set_lane(0, 1, 0, 0, 7, 1, 42);
    #3 chk("t3_old7", dout[0].old_dest_tag, 7);
    next_cycle();
    set_lane(0, 1, 0, 7, 0, 0, 0);
    cdb_tb[1].valid = 1'b1;
    cdb_tb[1].tag   = 6'd42;
    #3;
    chk("t3_byp_tag", dout[0].src2_tag, 42);
    chk("t3_byp_rdy", dout[0].src2_ready, 1);
    next_cycle();
    set_lane(0, 1, 7, 0, 0, 0, 0);
    #3 chk("t3_e7_rdy", dout[0].src1_ready, 1);

    // Rename beats a CDB completion of the old tag on the same entry.
    next_cycle();
    set_lane(0, 1, 0, 0, 7, 1, 50);
    next_cycle();
    set_lane(0, 1, 0, 0, 7, 1, 43);
    cdb_tb[0].valid = 1'b1;
    cdb_tb[0].tag   = 6'd50;
    #3 chk("t4_old7", dout[0].old_dest_tag, 50);
    next_cycle();
    set_lane(0, 1, 7, 0, 0, 0, 0);
    #3;
    chk("t4_e7_tag", dout[0].src1_tag, 43);
    chk("t4_e7_rdy", dout[0].src1_ready, 0);

    // Rollback with renames present: outputs muted, renames dropped.
    next_cycle();
    for (int i = 0; i < NUM_ENTRIES; i++) copy_tb[i] = 6'(i + 32);
    rollback = 1'b1;
    set_lane(0, 1, 1, 2, 1, 1, 9);
    set_lane(1, 1, 3, 4, 5, 1, 10);
    #3;
    chk("t5_l0_out", dout[0], 0);
    chk("t5_l1_out", dout[1], 0);
    next_cycle();
    rollback = 1'b0;
    set_lane(0, 1, 1, 31, 0, 0, 0);
    set_lane(1, 1, 3, 5, 0, 0, 0);
    #3;
    chk("t5_e1_tag",  dout[0].src1_tag, 33);
    chk("t5_e1_rdy",  dout[0].src1_ready, 1);
    chk("t5_e31_tag", dout[0].src2_tag, 63);
    chk("t5_e3_tag",  dout[1].src1_tag, 35);
    chk("t5_e5_tag",  dout[1].src2_tag, 37);
    chk("t5_e5_rdy",  dout[1].src2_ready, 1);

    // Random traffic with occasional rollback and mid-cycle reset.
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      if (reset) reset = 1'b0;
      rollback = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < NUM_ENTRIES; i++) copy_tb[i] = 6'($urandom);
      for (int k = 0; k < SCALAR; k++) begin
        set_lane(k, $urandom_range(0, 3) != 0, pick_reg(), pick_reg(), pick_reg(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 63));
        cdb_tb[k].valid = 1'($urandom_range(0, 1));
        cdb_tb[k].tag   = ($urandom_range(0, 3) != 0) ? 6'(m_tag[pick_reg()]) : 6'($urandom);
      end
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
      end
    end

    // Asynchronous reset between edges during rename traffic.
    next_cycle();
    reset = 1'b0;
    set_lane(0, 1, 9, 12, 9, 1, 60);
    set_lane(1, 1, 7, 0, 12, 1, 61);
    cdb_tb[0].valid = 1'b1;
    cdb_tb[0].tag   = 6'd61;
    #2 reset = 1'b1;
    #1;
    chk("t6_l0_src1_tag", dout[0].src1_tag, 9);
    chk("t6_l0_src1_rdy", dout[0].src1_ready, 1);
    chk("t6_l0_src2_tag", dout[0].src2_tag, 12);
    chk("t6_l1_src1_tag", dout[1].src1_tag, 7);
    chk("t6_l1_src1_rdy", dout[1].src1_ready, 1);
    chk("t6_l0_old",      dout[0].old_dest_tag, 9);
    chk("t6_l1_old",      dout[1].old_dest_tag, 12);
    next_cycle();
    reset = 1'b0;
    for (int n = 0; n < 20; n++) begin
      next_cycle();
      for (int k = 0; k < SCALAR; k++)
        set_lane(k, 1, pick_reg(), pick_reg(), pick_reg(), 1, $urandom_range(0, 63));
    end
    next_cycle();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
